// File: rtl/cmp_search_ctrl.sv
// Binary-search controller driving the b operand of a magnitude comparator until it reports equality.
// Optional PROBE_COUNT_EN adds a probe_cnt output counting SEARCH cycles of the last search.
module cmp_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic             lt_in,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result
`ifdef PROBE_COUNT_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0] probe_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] ONE     = 1;
  localparam logic [WIDTH:0]   ONE_EXT = 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] lo, lo_next;
  logic [WIDTH-1:0] hi, hi_next;
  logic [WIDTH-1:0] probe_next;
  logic             found_next;
  logic             error_next;
  logic [WIDTH-1:0] result_next;

`ifdef PROBE_COUNT_EN
  localparam int CNT_W = $clog2(WIDTH+2);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] cnt, cnt_next;
  assign probe_cnt = cnt;
`endif

  // Midpoint taken one bit wider so lo+hi never wraps.
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic [WIDTH:0] s;
    s = a + b;
    return s[WIDTH:1];
  endfunction

  assign busy = (state == SEARCH);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= MAX;
      probe  <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
      result <= '0;
`ifdef PROBE_COUNT_EN
      cnt    <= '0;
`endif
    end else begin
      state  <= state_next;
      lo     <= lo_next;
      hi     <= hi_next;
      probe  <= probe_next;
      found  <= found_next;
      error  <= error_next;
      result <= result_next;
`ifdef PROBE_COUNT_EN
      cnt    <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next  = state;
    lo_next     = lo;
    hi_next     = hi;
    probe_next  = probe;
    found_next  = found;
    error_next  = error;
    result_next = result;
`ifdef PROBE_COUNT_EN
    cnt_next    = cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          lo_next     = '0;
          hi_next     = MAX;
          probe_next  = mid('0, {1'b0, MAX});
          found_next  = 1'b0;
          error_next  = 1'b0;
          result_next = '0;
`ifdef PROBE_COUNT_EN
          cnt_next    = '0;
`endif
          state_next  = SEARCH;
        end
      end
      SEARCH: begin
`ifdef PROBE_COUNT_EN
        cnt_next = cnt + CNT_ONE;
`endif
        // Exhausted-range checks keep probe+1 and probe-1 inside [lo,hi].
        case ({eq_in, gt_in, lt_in})
          3'b100: begin
            result_next = probe;
            found_next  = 1'b1;
            state_next  = DONE;
          end
          3'b010: begin
            if (probe == hi) begin
              error_next = 1'b1;
              state_next = DONE;
            end else begin
              lo_next    = probe + ONE;
              probe_next = mid({1'b0, probe} + ONE_EXT, {1'b0, hi});
            end
          end
          3'b001: begin
            if (probe == lo) begin
              error_next = 1'b1;
              state_next = DONE;
            end else begin
              hi_next    = probe - ONE;
              probe_next = mid({1'b0, lo}, {1'b0, probe} - ONE_EXT);
            end
          end
          default: begin
            error_next = 1'b1;
            state_next = DONE;
          end
        endcase
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed self-checking bench for cmp_search_ctrl with a behavioural comparator model.
// Build with PROBE_COUNT_EN defined to also check probe_cnt.
module tb_cmp_search_ctrl;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst, start, eq_in, gt_in, lt_in;
  logic [WIDTH-1:0] probe, result;
  logic busy, done, found, error;
`ifdef PROBE_COUNT_EN
  logic [$clog2(WIDTH+2)-1:0] probe_cnt;
`endif

  logic [WIDTH-1:0] target;
  int mode;
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int seen_q[$];

  cmp_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .eq_in(eq_in), .gt_in(gt_in), .lt_in(lt_in),
    .probe(probe), .busy(busy), .done(done), .found(found),
    .error(error), .result(result)
`ifdef PROBE_COUNT_EN
    , .probe_cnt(probe_cnt)
`endif
  );

  always #5 clk = ~clk;

  // mode 0: honest comparator, 1: eq and gt both set, 2: gt at 7 then lt everywhere else
  always_comb begin
    eq_in = (target == probe);
    gt_in = (target > probe);
    lt_in = (target < probe);
    if (mode == 1) begin
      eq_in = 1'b1; gt_in = 1'b1; lt_in = 1'b0;
    end else if (mode == 2) begin
      eq_in = 1'b0; gt_in = (probe == 4'd7); lt_in = (probe != 4'd7);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_probe"}, 32'(probe), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_found"}, 32'(found), 0);
    checkOutput({tag, "_error"}, 32'(error), 0);
    checkOutput({tag, "_result"}, 32'(result), 0);
`ifdef PROBE_COUNT_EN
    checkOutput({tag, "_cnt"}, 32'(probe_cnt), 0);
`endif
  endtask

  // Runs one search; exp_q holds the hand-computed probe sequence. poke<0 means no stray start.
  task automatic applyStimulus(input string name, input logic [WIDTH-1:0] tgt, input int m,
                               input int poke, input logic exp_found, input logic exp_error,
                               input logic [WIDTH-1:0] exp_result);
    bit seen;
    seen = 0;
    target = tgt;
    mode = m;
    seen_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) seen_q.push_back(int'(probe));
        start = (i == poke);
        @(negedge clk);
      end
    end
    start = 1'b0;
    checkOutput({name, "_done_seen"}, 32'(seen), 1);
    checkOutput({name, "_busy_in_done"}, 32'(busy), 0);
    checkOutput({name, "_found"}, 32'(found), 32'(exp_found));
    checkOutput({name, "_error"}, 32'(error), 32'(exp_error));
    checkOutput({name, "_result"}, 32'(result), 32'(exp_result));
`ifdef PROBE_COUNT_EN
    checkOutput({name, "_cnt"}, 32'(probe_cnt), 32'(exp_q.size()));
`endif
    checkOutput({name, "_nprobes"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      checkOutput($sformatf("%s_probe%0d", name, i),
                  (i < seen_q.size()) ? 32'(seen_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    @(negedge clk);
    checkOutput({name, "_done_pulse_len"}, 32'(done), 0);
    checkOutput({name, "_idle_busy"}, 32'(busy), 0);
    checkOutput({name, "_result_held"}, 32'(result), 32'(exp_result));
    checkOutput({name, "_found_held"}, 32'(found), 32'(exp_found));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    target = '0;
    mode = 0;
    repeat (2) @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;
    @(negedge clk);
    checkIdleZero("post_reset");

    exp_q = '{7};
    applyStimulus("t7", 4'd7, 0, -1, 1'b1, 1'b0, 4'd7);

    exp_q = '{7};
    applyStimulus("illegal", 4'd7, 1, -1, 1'b0, 1'b1, 4'd0);

    exp_q = '{7, 11, 13, 14, 15};
    applyStimulus("t15_poke", 4'd15, 0, 2, 1'b1, 1'b0, 4'd15);

    exp_q = '{7, 3, 1, 0};
    applyStimulus("t0", 4'd0, 0, -1, 1'b1, 1'b0, 4'd0);

    exp_q = '{7, 11, 9, 8};
    applyStimulus("contra", 4'd0, 2, -1, 1'b0, 1'b1, 4'd0);

    // Abandon a search mid-way with an asynchronous reset
    target = 4'd15;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy), 1);
    checkOutput("pre_rst_probe", 32'(probe), 11);
    #2 rst = 1'b1;
    #1;
    checkIdleZero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_no_done%0d", i), 32'(done), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkIdleZero("rst_release");

    exp_q = '{7, 11, 9, 10};
    applyStimulus("t10_after_rst", 4'd10, 0, -1, 1'b1, 1'b0, 4'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
